// File: rtl/fenwick_pkg.sv
// Shared op codes, status codes and FSM states for the Fenwick MMIO initiator.
package fenwick_pkg;

    typedef enum logic [1:0] {
        OP_BUILD  = 2'b00,
        OP_QUERY  = 2'b01,
        OP_UPDATE = 2'b10,
        OP_NOP    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK    = 2'b00,
        ST_FULL  = 2'b01,
        ST_RANGE = 2'b10,
        ST_BADOP = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        READ,
        SAMPLE,
        RESP
    } state_e;

endpackage

// File: rtl/fenwick_req_check.sv
// Combinational request validation; the first failing check determines the status.
module fenwick_req_check
    import fenwick_pkg::*;
#(
    parameter int ARR_SIZE = 100,
    parameter int IDX_W    = $clog2(ARR_SIZE) + 2,
    parameter int CNT_W    = $clog2(ARR_SIZE + 1)
) (
    input  op_e              op,
    input  logic [IDX_W-1:0] idx,
    input  logic [IDX_W-1:0] ql,
    input  logic [IDX_W-1:0] qr,
    input  logic [CNT_W-1:0] build_count,
    output status_e          status
);

    localparam logic [IDX_W-1:0] LIMIT_IDX = IDX_W'(ARR_SIZE);
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(ARR_SIZE);

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves status unassigned (no latch).
        status = ST_OK;
        if (op == OP_NOP)
            status = ST_BADOP;
        else if (op == OP_BUILD && build_count == LIMIT_CNT)
            status = ST_FULL;
        else if (op == OP_UPDATE && idx >= LIMIT_IDX)
            status = ST_RANGE;
        else if (op == OP_QUERY && (qr >= LIMIT_IDX || ql > qr))
            status = ST_RANGE;
    end

endmodule

// File: rtl/fenwick_mmio_initiator.sv
// Requester for the Fenwick SoC register interface: validates requests, sequences
// the SoC pins, captures query sums through an MMIO result register, returns responses.
module fenwick_mmio_initiator
    import fenwick_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ARR_SIZE = 100,
    parameter int IDX_W    = $clog2(ARR_SIZE) + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [IDX_W-1:0]  req_idx,
    input  logic [IDX_W-1:0]  req_ql,
    input  logic [IDX_W-1:0]  req_qr,
    input  logic [DATA_W-1:0] req_value,
    input  logic [1:0]        req_slot,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [1:0]        resp_status,
    output logic [DATA_W-1:0] resp_data,
    output logic [1:0]        soc_cmd,
    output logic [IDX_W-1:0]  soc_uindex,
    output logic [IDX_W-1:0]  soc_ql,
    output logic [IDX_W-1:0]  soc_qr,
    output logic [DATA_W-1:0] soc_uvalue,
    output logic [DATA_W-1:0] soc_ivalue,
    output logic              soc_wen,
    output logic [1:0]        soc_addr,
    input  logic [DATA_W-1:0] soc_out
);

    localparam int CNT_W = $clog2(ARR_SIZE + 1);

    state_e           state;
    op_e              op_q;
    op_e              req_op_e;
    logic [1:0]       slot_q;
    logic [CNT_W-1:0] build_count;
    status_e          chk_status;

    assign req_op_e = op_e'(req_op);

    fenwick_req_check #(
        .ARR_SIZE (ARR_SIZE),
        .IDX_W    (IDX_W),
        .CNT_W    (CNT_W)
    ) u_check (
        .op          (req_op_e),
        .idx         (req_idx),
        .ql          (req_ql),
        .qr          (req_qr),
        .build_count (build_count),
        .status      (chk_status)
    );

    // NOTE: every register here updates with <= so all state moves together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= OP_NOP;
            slot_q      <= 2'b00;
            build_count <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_status <= ST_OK;
            resp_data   <= '0;
            soc_cmd     <= OP_NOP;
            soc_wen     <= 1'b0;
            soc_addr    <= 2'b00;
            soc_uindex  <= '0;
            soc_ql      <= '0;
            soc_qr      <= '0;
            soc_uvalue  <= '0;
            soc_ivalue  <= '0;
        end else begin
            // The SoC sees a real command only in the single ISSUE cycle.
            soc_cmd <= OP_NOP;
            soc_wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        op_q      <= req_op_e;
                        slot_q    <= req_slot;
                        if (chk_status != ST_OK) begin
                            resp_valid  <= 1'b1;
                            resp_status <= chk_status;
                            resp_data   <= '0;
                            state       <= RESP;
                        end else begin
                            soc_cmd <= req_op;
                            case (req_op_e)
                                OP_BUILD: soc_ivalue <= req_value;
                                OP_UPDATE: begin
                                    soc_uindex <= req_idx;
                                    soc_uvalue <= req_value;
                                end
                                OP_QUERY: begin
                                    soc_ql <= req_ql;
                                    soc_qr <= req_qr;
                                end
                                default: ;
                            endcase
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (op_q == OP_QUERY) begin
                        soc_wen  <= 1'b1;
                        soc_addr <= slot_q;
                        state    <= CAPTURE;
                    end else begin
                        if (op_q == OP_BUILD)
                            build_count <= build_count + 1'b1;
                        resp_valid  <= 1'b1;
                        resp_status <= ST_OK;
                        resp_data   <= '0;
                        state       <= RESP;
                    end
                end
                CAPTURE: state <= READ;
                READ:    state <= SAMPLE;
                SAMPLE: begin
                    resp_valid  <= 1'b1;
                    resp_status <= ST_OK;
                    resp_data   <= soc_out;
                    state       <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fenwick_mmio_initiator.md
# fenwick_mmio_initiator

Bus-master front end for the memory-mapped Fenwick-tree SoC. It accepts build/update/query requests on a valid/ready request channel and range-checks them. It drives the SoC's cmd/operand/wen/addr pins with the exact cycle sequence the SoC needs, captures query sums through the selected MMIO result register, and returns status and data on a valid/ready response channel. It sits between a host or testbench sequencer and the Fenwick SoC; it is the requester end of that SoC's register interface.

## Interface
- DATA_W, 32, width of values and sums
- ARR_SIZE, 100, element count of the attached Fenwick SoC
- IDX_W, $clog2(ARR_SIZE)+2, index width; matches the SoC's index ports
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; also routed to the SoC
- req_valid  in  1  request offered
- req_ready  out  1  initiator can accept
- req_op  in  2  00 build, 01 query, 10 update, 11 reserved
- req_idx  in  IDX_W  update index
- req_ql / req_qr  in  IDX_W  inclusive query bounds
- req_value  in  DATA_W  build value or update value
- req_slot  in  2  MMIO result register used for a query
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_status  out  2  00 OK, 01 FULL, 10 RANGE, 11 BADOP
- resp_data  out  DATA_W  query sum; 0 for all other responses
- soc_cmd  out  2  SoC command; 11 is NOP
- soc_uindex, soc_ql, soc_qr  out  IDX_W  SoC operands
- soc_uvalue, soc_ivalue  out  DATA_W  SoC operands
- soc_wen  out  1  MMIO write enable (1 = latch core result into register addr)
- soc_addr  out  2  MMIO register select
- soc_out  in  DATA_W  SoC registered read data

## Operation
- All soc_* and resp_* outputs are registered. The values listed per state are the values present during that state.
- Default drive in every state except ISSUE: soc_cmd=11 (NOP), soc_wen=0, operands hold their last value.
- An internal build_count (0..ARR_SIZE) mirrors the SoC fill pointer.
  - rst clears it.
  - It increments on every successful build.
- IDLE: req_ready=1.
  - On handshake, latch all request fields and evaluate the checks in this order.
  - req_op=11 → BADOP.
  - Build with build_count==ARR_SIZE → FULL.
  - Update with req_idx≥ARR_SIZE → RANGE.
  - Query with req_qr≥ARR_SIZE or req_ql>req_qr → RANGE.
  - On any error, go to RESP without touching the SoC. Otherwise go to ISSUE.
- ISSUE (1 cycle): soc_cmd = req_op.
  - Build: soc_ivalue = req_value.
  - Update: soc_uindex = req_idx, soc_uvalue = req_value.
  - Query: soc_ql = req_ql, soc_qr = req_qr.
  - Build/update → RESP with OK. Query → CAPTURE.
- CAPTURE: soc_wen=1, soc_addr=slot → READ.
- READ: soc_wen=0, soc_addr=slot → SAMPLE.
- SAMPLE: latch soc_out into resp_data → RESP with OK.
- RESP: resp_valid=1. Hold resp_status and resp_data stable until resp_ready, then go to IDLE.
- req_ready=0 in every state except IDLE. Only one request is in flight.
- Arithmetic is the SoC's: modulo 2^DATA_W. The initiator does no sum math.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_status=00, resp_data=0, soc_cmd=11, soc_wen=0, soc_addr=00, all operands 0, state IDLE.
- Latency, counted from the handshake edge to the first resp_valid cycle:
  - Error: 1 cycle.
  - Build or update: 2 cycles.
  - Query: 5 cycles.
- Back-to-back: if resp_ready is high in the first RESP cycle, IDLE follows and the next request can be accepted 1 cycle later.
- resp_valid never drops without resp_ready.
- rst asserted in any state aborts the operation, suppresses its response, and forces the reset values on the next edge.
- req fields are ignored outside IDLE. No request is lost, because req_ready is low.
- soc_cmd is never build, query or update outside ISSUE. This guarantees the SoC's build pointer advances exactly once per accepted build.

## Structure
- Shared package fenwick_pkg holds:
  - op codes: OP_BUILD=00, OP_QUERY=01, OP_UPDATE=10, OP_NOP=11
  - status codes: OK, FULL, RANGE, BADOP
  - the state enum: IDLE, ISSUE, CAPTURE, READ, SAMPLE, RESP
- One combinational sub-module, fenwick_req_check, takes op, indices and build_count, and returns the status using the check order above.
- The FSM, output registers and build_count live in the top.

## Test plan
- Reset, then build values 1,2,3,4,5 → five OK responses, each 2 cycles after its handshake; soc_cmd=00 for exactly one cycle per request.
- Query ql=1, qr=3, slot=2 → OK with resp_data=9, 5 cycles after handshake; soc_wen=1 with soc_addr=2 in exactly one cycle.
- Update idx=2 to 10, then query 0..4 on slot 0 → OK, then OK with resp_data=22.
- Error paths, each answered 1 cycle after handshake with no soc_cmd activity:
  - query ql=3, qr=1 → RANGE
  - update idx=ARR_SIZE → RANGE
  - op 11 → BADOP
- With ARR_SIZE=4: build 4 values → OK; 5th build → FULL; build_count stays 4.
- Hold resp_ready=0 for 3 cycles on a query → resp_valid and resp_data stay stable.
- Assert rst during CAPTURE → no response; req_ready=1 and soc_cmd=11 on the next cycle.
